bcd_mod_counter: RTL
====================

// Module: bcd_mod_counter
//
// PURPOSE
//   Parametrised two-digit BCD modulo counter with integrated 7-segment drive for the digital clock.
//   Generalises the single-digit seconds stage: configurable modulus (60 for sec/min, 24 for hours),
//   optional internal prescaler or external tick, carry chaining, pause and a manual time-set mode.
//   Instances are chained: carry_out of one stage drives tick_in of the next (PRESCALE=0).
//
// PARAMETERS
//   MODULUS        60      count range 0..MODULUS-1; legal 2..100
//   PRESCALE       500000  clocks per internal tick; 0 = use tick_in directly
//   SEG_ACTIVE_LOW 1       1: segment on = 0 (board default); 0: segment on = 1
//
// PORTS
//   clock     in   1  system clock, all logic on rising edge
//   reset_n   in   1  asynchronous, active-low reset
//   tick_in   in   1  one-cycle advance pulse; used only when PRESCALE=0
//   run       in   1  1 = count, 0 = hold (prescaler and digits frozen)
//   set_mode  in   1  1 = manual set: ticks ignored, inc_btn_n advances value
//   inc_btn_n in   1  raw active-low push button, asynchronous to clock
//   clear     in   1  synchronous clear of digits and prescaler
//   carry_out out  1  one-cycle pulse on tick-driven wrap MODULUS-1 -> 0
//   ones      out  4  BCD units digit
//   tens      out  4  BCD tens digit
//   seg_ones  out  7  units segments {g,f,e,d,c,b,a}
//   seg_tens  out  7  tens segments {g,f,e,d,c,b,a}
//
// BEHAVIOUR
//   Reset (async, reset_n=0): ones=tens=0, prescaler=0, carry_out=0, button sync regs=1,
//     seg_* = "0" glyph (7'b1000000 active-low / 7'b0111111 active-high). Applies mid-operation.
//   Tick source: PRESCALE=0 -> tick=tick_in. Else prescaler counts 0..PRESCALE-1 while
//     run=1 && set_mode=0; tick asserted for the cycle it is at PRESCALE-1, then wraps to 0.
//   Button: 2-FF synchroniser + falling-edge detect -> inc pulse; digits change on the
//     3rd rising edge after inc_btn_n first sampled low. Held button = one increment.
//   Priority per cycle: clear > (set_mode && inc) > (run && !set_mode && tick). Lower ignored.
//   Increment: if {tens,ones}==MODULUS-1 -> 0,0; else if ones==9 -> ones=0, tens+1; else ones+1.
//     Value never leaves 0..MODULUS-1; BCD digits never exceed 9.
//   carry_out: registered, high exactly the cycle after a tick-driven wrap. No carry on
//     set-mode wrap, clear, or reset. tick while run=0 is dropped, not queued.
//   Latency: tick/inc-pulse at edge N -> digits update at N; seg_* registered, update at N+1.
//   Decode (active-low, {g..a}): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//     5=0010010 6=0000010 7=1111000 8=0000000 9=0010000; active-high = bitwise inverse.
//   clear: digits and prescaler to 0 next edge; carry_out=0 that cycle.
//
// STRUCTURE
//   Package clock_pkg: SEG_W=7, seg_t typedef, 10-entry active-low glyph constant table,
//     SEG_BLANK constant.
//   Sub-module bcd_to_7seg (4-bit BCD in, 7-bit seg out, ACTIVE_LOW param), combinational;
//     two instances, outputs registered in this block.
//   Prescaler generated only when PRESCALE>0 (generate block).
//
// TESTING
//   T1 reset_n=0 mid-count at 37 -> ones=0,tens=0,carry_out=0,seg_ones=1000000 immediately.
//   T2 MODULUS=60,PRESCALE=0,run=1: 59 tick_in pulses -> tens=5,ones=9; 60th -> 00, carry_out 1 cycle.
//   T3 MODULUS=24: 9 ticks -> 09, 10th -> 10 (seg_tens=1111001 next cycle); 24th -> 00 + carry.
//   T4 PRESCALE=4,run=1 for 12 clocks -> value 3; run=0 for 20 clocks -> value stays 3.
//   T5 set_mode=1 at 58, 3 button presses + tick_in pulses -> 58,59,00,01 only; carry_out stays 0.
//   T6 clear and tick same cycle at 59 -> value 00, carry_out 0; button bounce <1 clk -> no inc.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and constants for the digital-clock display path.
// Glyphs are stored active-low in {g,f,e,d,c,b,a} order; decoders invert as needed.
package clock_pkg;

    localparam int SEG_W = 7;

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t GLYPH_AL [10] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to 7-segment decoder; non-BCD codes show a blank digit.
module bcd_to_7seg
    import clock_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] bcd,
    output seg_t       seg
);

    seg_t raw;

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        raw = SEG_BLANK;
        if (bcd <= 4'd9) begin
            raw = GLYPH_AL[bcd];
        end
        seg = ACTIVE_LOW ? raw : ~raw;
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter with prescaler or external tick, carry chaining,
// pause, manual set via push button, and registered 7-segment outputs.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int MODULUS        = 60,
    parameter int PRESCALE       = 500000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tick_in,
    input  logic       run,
    input  logic       set_mode,
    input  logic       inc_btn_n,
    input  logic       clear,
    output logic       carry_out,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output seg_t       seg_ones,
    output seg_t       seg_tens
);

    localparam logic [3:0] LAST_TENS = 4'((MODULUS - 1) / 10);
    localparam logic [3:0] LAST_ONES = 4'((MODULUS - 1) % 10);
    localparam bit         SEG_AL    = (SEG_ACTIVE_LOW != 0);
    localparam seg_t       SEG_ZERO  = SEG_AL ? GLYPH_AL[0] : ~GLYPH_AL[0];

    logic       count_en;
    logic       tick;
    logic [2:0] btn_sync;
    logic       inc_pulse;
    logic       set_inc;
    logic       tick_adv;
    logic       at_last;
    seg_t       dec_ones;
    seg_t       dec_tens;

    assign count_en = run & ~set_mode;

    // Stages 0-1 synchronise the raw button; stage 2 holds the previous level for edge detect.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            btn_sync <= '1;
        end else begin
            // NOTE: state registers use non-blocking assignment so every stage samples pre-edge values.
            btn_sync <= {btn_sync[1:0], inc_btn_n};
        end
    end

    assign inc_pulse = btn_sync[2] & ~btn_sync[1];

    generate
        if (PRESCALE > 0) begin : gen_presc
            localparam int            PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
            localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] presc;
            logic          unused_tick_in;

            assign unused_tick_in = tick_in;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    presc <= '0;
                end else if (clear) begin
                    presc <= '0;
                end else if (count_en) begin
                    presc <= (presc == P_LAST) ? '0 : presc + PW'(1);
                end
            end

            assign tick = (presc == P_LAST);
        end else begin : gen_ext_tick
            assign tick = tick_in;
        end
    endgenerate

    assign set_inc  = set_mode & inc_pulse;
    assign tick_adv = count_en & tick;
    assign at_last  = (tens == LAST_TENS) && (ones == LAST_ONES);

    // Priority: clear, then manual increment, then tick; only a tick-driven wrap carries.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ones      <= 4'd0;
            tens      <= 4'd0;
            carry_out <= 1'b0;
        end else begin
            carry_out <= 1'b0;
            if (clear) begin
                ones <= 4'd0;
                tens <= 4'd0;
            end else if (set_inc || tick_adv) begin
                carry_out <= tick_adv & at_last;
                if (at_last) begin
                    ones <= 4'd0;
                    tens <= 4'd0;
                end else if (ones == 4'd9) begin
                    ones <= 4'd0;
                    tens <= tens + 4'd1;
                end else begin
                    ones <= ones + 4'd1;
                end
            end
        end
    end

    bcd_to_7seg #(.ACTIVE_LOW(SEG_AL)) u_dec_ones (
        .bcd (ones),
        .seg (dec_ones)
    );

    bcd_to_7seg #(.ACTIVE_LOW(SEG_AL)) u_dec_tens (
        .bcd (tens),
        .seg (dec_tens)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seg_ones <= SEG_ZERO;
            seg_tens <= SEG_ZERO;
        end else begin
            seg_ones <= dec_ones;
            seg_tens <= dec_tens;
        end
    end

endmodule
